// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier: one Booth triplet per clock, signed N x N -> 2N.
// Optional macro BOOTH_EARLY_TERM_EN stops once the remaining triplets all encode zero and adds iter_count.
module booth_seq_ctrl #(
    parameter int N = 8,
    localparam int CW = $clog2(N / 2) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      multiplicand,
    input  logic [N-1:0]      multiplier,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*N-1:0]    product,
    output logic              busy
`ifdef BOOTH_EARLY_TERM_EN
    ,
    output logic [CW-1:0]     iter_count
`endif
);

    localparam int AW   = 2 * N + 2;
    localparam int LAST = N / 2 - 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   mcand_q;
    logic [N-1:0]    mplier_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  product_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
`ifdef BOOTH_EARLY_TERM_EN
    logic [CW-1:0]   iter_count_q;
`endif

    logic [N:0]      qExt_d;
    logic [2:0]      triplet_d;
    logic [AW-1:0]   term_d;
    logic [AW-1:0]   accSum_d;
    logic            finish_d;
`ifdef BOOTH_EARLY_TERM_EN
    logic            anyOne_d;
    logic            anyZero_d;
`endif

    // The appended zero supplies the implicit Q[-1] bit for the first triplet.
    always_comb begin
        qExt_d    = {mplier_q, 1'b0};
        triplet_d = qExt_d[{cnt_q, 1'b0} +: 3];
        term_d    = '0;
        case (triplet_d)
            3'b001, 3'b010: term_d = mcand_q;
            3'b011:         term_d = mcand_q << 1;
            3'b100:         term_d = ~(mcand_q << 1) + AW'(1);
            3'b101, 3'b110: term_d = ~mcand_q + AW'(1);
            default:        term_d = '0;
        endcase
        accSum_d = acc_q + (term_d << {cnt_q, 1'b0});
        finish_d = (cnt_q == CW'(LAST));
`ifdef BOOTH_EARLY_TERM_EN
        // Uniform Q bits above 2i are pure sign extension, so every later triplet is 000 or 111.
        anyOne_d  = 1'b0;
        anyZero_d = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (j >= 2 * int'(cnt_q) + 1) begin
                if (mplier_q[j]) anyOne_d = 1'b1;
                else             anyZero_d = 1'b1;
            end
        end
        if (!(anyOne_d && anyZero_d)) finish_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            product_q    <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef BOOTH_EARLY_TERM_EN
            iter_count_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!abort && in_valid) begin
                        mcand_q    <= {{(N + 2){multiplicand[N-1]}}, multiplicand};
                        mplier_q   <= multiplier;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q    <= IDLE;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        acc_q <= accSum_d;
                        if (finish_d) begin
                            product_q    <= accSum_d[2*N-1:0];
                            state_q      <= DONE;
                            out_valid_q  <= 1'b1;
`ifdef BOOTH_EARLY_TERM_EN
                            iter_count_q <= cnt_q + CW'(1);
`endif
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;
`ifdef BOOTH_EARLY_TERM_EN
    assign iter_count = iter_count_q;
`endif

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl (N=8): scoreboard of expected products and RUN-cycle counts.
// Expected latency follows BOOTH_EARLY_TERM_EN when that macro is defined for the build.
module tb_booth_seq_ctrl;

    localparam int N      = 8;
    localparam int CW     = $clog2(N / 2) + 1;
    localparam int BUDGET = 20;
`ifdef BOOTH_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           abort;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;
`ifdef BOOTH_EARLY_TERM_EN
    logic [CW-1:0]  iter_count;
`endif

    booth_seq_ctrl #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .abort        (abort),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
`ifdef BOOTH_EARLY_TERM_EN
        ,
        .iter_count   (iter_count)
`endif
    );

    typedef struct {
        logic [2*N-1:0] prod;
        int             cycles;
    } exp_t;

    exp_t scoreQ[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backstop so a wedged handshake can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // RUN cycles needed if iteration stops after the last triplet that is not 000/111.
    function automatic int earlyCycles(input logic [N-1:0] q);
        logic [N:0] qe;
        logic [2:0] t;
        int         last;
        qe   = {q, 1'b0};
        last = 0;
        for (int i = 0; i < N / 2; i++) begin
            t = qe[2*i +: 3];
            if (t != 3'b000 && t != 3'b111) last = i + 1;
        end
        return (last == 0) ? 1 : last;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] m, input logic [N-1:0] q, input bit track);
        exp_t e;
        int   p;
        @(negedge clk);
        checkOutput("inReadyBeforeAccept", {31'b0, in_ready}, 32'd1);
        multiplicand = m;
        multiplier   = q;
        in_valid     = 1'b1;
        if (track) begin
            p        = int'($signed(m)) * int'($signed(q));
            e.prod   = p[2*N-1:0];
            e.cycles = EARLY ? earlyCycles(q) : N / 2;
            scoreQ.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
        checkOutput("busyAfterAccept", {31'b0, busy}, 32'd1);
    endtask

    task automatic collectResult(input string tag, input bit doHandshake);
        exp_t e;
        int   cycles;
        cycles = 0;
        while (!out_valid && cycles < BUDGET) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!out_valid) checkOutput({tag, "_inReadyLow"}, {31'b0, in_ready}, 32'd0);
        end
        if (!out_valid) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
            if (scoreQ.size() > 0) void'(scoreQ.pop_front());
            return;
        end
        if (scoreQ.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'd1, 32'd0);
            return;
        end
        e = scoreQ.pop_front();
        checkOutput({tag, "_product"}, {16'b0, product}, {16'b0, e.prod});
        checkOutput({tag, "_latency"}, cycles, e.cycles);
`ifdef BOOTH_EARLY_TERM_EN
        checkOutput({tag, "_iterCount"}, {29'b0, iter_count}, e.cycles);
`endif
        if (doHandshake) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            checkOutput({tag, "_validDrop"}, {31'b0, out_valid}, 32'd0);
            checkOutput({tag, "_backToIdle"}, {31'b0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        int seen;
        rst          = 1'b1;
        in_valid     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        abort        = 1'b0;
        out_ready    = 1'b1;
        #1;
        checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
        checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstBusy", {31'b0, busy}, 32'd0);
        checkOutput("rstProduct", {16'b0, product}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a multiply must discard it without a result pulse.
        applyStimulus(8'sd7, -8'sd3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRstInReady", {31'b0, in_ready}, 32'd1);
        checkOutput("midRstOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
        checkOutput("midRstProduct", {16'b0, product}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("noPulseAfterRst", seen, 32'd0);

        applyStimulus(8'sd7, -8'sd3, 1'b1);
        collectResult("m7q-3", 1'b1);
        applyStimulus(8'h80, 8'h80, 1'b1);
        collectResult("minXmin", 1'b1);
        applyStimulus(8'sd127, 8'sd127, 1'b1);
        collectResult("maxXmax", 1'b1);
        applyStimulus(8'h80, 8'sd127, 1'b1);
        collectResult("minXmax", 1'b1);
        applyStimulus(8'sd0, 8'hFF, 1'b1);
        collectResult("zeroXneg1", 1'b1);
        applyStimulus(8'sd100, 8'sd1, 1'b1);
        collectResult("m100q1", 1'b1);
        applyStimulus(8'sd2, 8'h80, 1'b1);
        collectResult("m2qmin", 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(N'($urandom), N'($urandom), 1'b1);
            collectResult("random", 1'b1);
        end

        // Hold the result under backpressure while stray in_valid pulses arrive.
        out_ready = 1'b0;
        applyStimulus(8'sd5, 8'sd6, 1'b1);
        collectResult("backpressure", 1'b0);
        for (int k = 0; k < 10; k++) begin
            in_valid     = k[0];
            multiplicand = N'($urandom);
            multiplier   = N'($urandom);
            @(posedge clk);
            #1;
            checkOutput("bpHeldValid", {31'b0, out_valid}, 32'd1);
            checkOutput("bpHeldProduct", {16'b0, product}, 32'h001E);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bpReleaseValid", {31'b0, out_valid}, 32'd0);
        checkOutput("bpReleaseIdle", {31'b0, in_ready}, 32'd1);

        // Abort on the second RUN cycle; the old product must survive.
        applyStimulus(8'sd9, 8'sd9, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abortIdle", {31'b0, in_ready}, 32'd1);
        checkOutput("abortBusy", {31'b0, busy}, 32'd0);
        checkOutput("abortValid", {31'b0, out_valid}, 32'd0);
        checkOutput("abortProductKept", {16'b0, product}, 32'h001E);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checkOutput("noPulseAfterAbort", seen, 32'd0);

        // Abort wins over in_valid while idle.
        @(negedge clk);
        abort        = 1'b1;
        in_valid     = 1'b1;
        multiplicand = 8'sd1;
        multiplier   = 8'sd1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("idleAbortNoAccept", {31'b0, busy}, 32'd0);

        applyStimulus(8'sd3, 8'sd4, 1'b1);
        collectResult("afterAbort", 1'b1);

        checkOutput("scoreboardEmpty", scoreQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
